// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - shared types for the FPU subsystem result path
// Tag, metadata, x_result and buffer-entry layouts plus default widths.
package fpu_ss_pkg;

   localparam int unsigned DEF_NUM_CORES     = 2;
   localparam int unsigned DEF_ID_WIDTH      = 4;
   localparam int unsigned DEF_DATA_WIDTH    = 32;
   localparam int unsigned DEF_CORE_ID_WIDTH = 32;
   localparam int unsigned REG_ADDR_WIDTH    = 5;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0]    addr;
      logic                         rd_is_fp;
      logic [DEF_ID_WIDTH-1:0]      id;
      logic [DEF_CORE_ID_WIDTH-1:0] core_id;
   } fpu_tag_t;

   typedef struct packed {
      logic [DEF_ID_WIDTH-1:0]      id;
      logic [REG_ADDR_WIDTH-1:0]    rd;
      logic                         we;
      logic [DEF_CORE_ID_WIDTH-1:0] core_id;
   } mem_metadata_t;

   typedef struct packed {
      logic [DEF_ID_WIDTH-1:0]   id;
      logic [DEF_DATA_WIDTH-1:0] data;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      we;
      logic [2:0]                ecswe;
      logic [5:0]                ecsdata;
      logic                      exc;
      logic [5:0]                exccode;
   } x_result_t;

   typedef struct packed {
      logic [DEF_CORE_ID_WIDTH-1:0] core_id;
      logic [DEF_ID_WIDTH-1:0]      id;
      logic [REG_ADDR_WIDTH-1:0]    rd;
      logic                         we;
      logic [DEF_DATA_WIDTH-1:0]    data;
   } result_entry_t;

   typedef enum logic {SrcFpu, SrcMem} rr_src_e;

endpackage

// File: rtl/fpu_ss_result_fifo.sv
// rtl/fpu_ss_result_fifo.sv - DEPTH-entry result buffer with push/pop/flush/count
// Registered head only; a pushed entry is visible one cycle later at the earliest.
module fpu_ss_result_fifo
   import fpu_ss_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               push_i,
   input  result_entry_t      data_i,
   input  logic               pop_i,
   output result_entry_t      head_o,
   output logic               empty_o,
   output logic               full_o,
   output logic [CNT_W-1:0]   count_o
);

   result_entry_t    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en, rd_en;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign wr_en   = push_i && !full_o && !flush_i;
   assign rd_en   = pop_i && !empty_o && !flush_i;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/fpu_ss_result_router.sv
// rtl/fpu_ss_result_router.sv - merges FPU and LSU completions, routes by core_id
// Round-robin input arbiter, ordered buffer, one-hot per-core x_result valid.
module fpu_ss_result_router
   import fpu_ss_pkg::*;
#(
   parameter int unsigned NUM_CORES     = DEF_NUM_CORES,
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned ID_WIDTH      = DEF_ID_WIDTH,
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned CORE_ID_WIDTH = DEF_CORE_ID_WIDTH
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         fpu_valid_i,
   output logic                         fpu_ready_o,
   input  logic [DATA_WIDTH-1:0]        fpu_data_i,
   input  fpu_tag_t                     fpu_tag_i,
   input  logic                         mem_valid_i,
   output logic                         mem_ready_o,
   input  logic [DATA_WIDTH-1:0]        mem_data_i,
   input  mem_metadata_t                mem_meta_i,
   output logic [NUM_CORES-1:0]         result_valid_o,
   input  logic [NUM_CORES-1:0]         result_ready_i,
   output x_result_t                    result_o,
   output logic                         core_id_err_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   result_entry_t            push_entry, head;
   rr_src_e                  rr_q, rr_d;
   logic                     full, empty, push, pop, head_ok;
   logic                     fpu_gnt, mem_gnt, fpu_push, mem_push;
   logic [NUM_CORES-1:0]     head_sel;
   logic [CORE_ID_WIDTH-1:0] head_core;
   logic [ID_WIDTH-1:0]      head_id;

   // A source loses the slot only when the other one is valid and owns the turn.
   assign fpu_gnt     = !(mem_valid_i && (!fpu_valid_i || rr_q == SrcMem));
   assign mem_gnt     = !(fpu_valid_i && (!mem_valid_i || rr_q == SrcFpu));
   assign fpu_ready_o = !full && !flush_i && fpu_gnt;
   assign mem_ready_o = !full && !flush_i && mem_gnt;
   assign fpu_push    = fpu_valid_i && fpu_ready_o;
   assign mem_push    = mem_valid_i && mem_ready_o;
   assign push        = fpu_push || mem_push;

   always_comb begin
      push_entry.core_id = fpu_tag_i.core_id;
      push_entry.id      = fpu_tag_i.id;
      push_entry.rd      = fpu_tag_i.addr;
      push_entry.we      = ~fpu_tag_i.rd_is_fp;
      push_entry.data    = fpu_data_i;
      if (mem_push) begin
         push_entry.core_id = mem_meta_i.core_id;
         push_entry.id      = mem_meta_i.id;
         push_entry.rd      = mem_meta_i.rd;
         push_entry.we      = mem_meta_i.we;
         push_entry.data    = mem_data_i;
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (fpu_valid_i && mem_valid_i && push) rr_d = (rr_q == SrcFpu) ? SrcMem : SrcFpu;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= SrcFpu;
      else         rr_q <= rr_d;
   end

   fpu_ss_result_fifo #(.DEPTH(DEPTH)) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .head_o  (head),
      .empty_o (empty),
      .full_o  (full),
      .count_o (count_o)
   );

   assign head_core = head.core_id;
   assign head_id   = head.id;

   always_comb begin
      head_sel = '0;
      for (int c = 0; c < NUM_CORES; c++) head_sel[c] = (head_core == CORE_ID_WIDTH'(c));
   end

   // An out-of-range head has no channel to wait on, so it is dropped immediately.
   assign head_ok        = |head_sel;
   assign result_valid_o = empty ? '0 : head_sel;
   assign pop            = !empty && (head_ok ? |(head_sel & result_ready_i) : 1'b1);
   assign core_id_err_o  = !empty && !head_ok && !flush_i;

   always_comb begin
      result_o      = '0;
      result_o.id   = head_id;
      result_o.data = head.data;
      result_o.rd   = head.rd;
      result_o.we   = head.we;
   end

endmodule

// File: tb/tb_fpu_ss_result_router.sv
// tb/tb_fpu_ss_result_router.sv - scoreboard bench for fpu_ss_result_router
// Directed scenarios followed by randomized traffic against a queue model.
module tb_fpu_ss_result_router;
   import fpu_ss_pkg::*;

   localparam int NC  = 2;
   localparam int DEP = 4;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          flush_i = 1'b0;
   logic          fpu_valid_i = 1'b0, mem_valid_i = 1'b0;
   logic          fpu_ready_o, mem_ready_o;
   logic [31:0]   fpu_data_i = '0, mem_data_i = '0;
   fpu_tag_t      fpu_tag_i = '0;
   mem_metadata_t mem_meta_i = '0;
   logic [NC-1:0] result_valid_o;
   logic [NC-1:0] result_ready_i = '0;
   x_result_t     result_o;
   logic          core_id_err_o;
   logic [2:0]    count_o;

   always #5 clk = ~clk;

   fpu_ss_result_router #(.NUM_CORES(NC), .DEPTH(DEP)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .fpu_valid_i    (fpu_valid_i),
      .fpu_ready_o    (fpu_ready_o),
      .fpu_data_i     (fpu_data_i),
      .fpu_tag_i      (fpu_tag_i),
      .mem_valid_i    (mem_valid_i),
      .mem_ready_o    (mem_ready_o),
      .mem_data_i     (mem_data_i),
      .mem_meta_i     (mem_meta_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_o       (result_o),
      .core_id_err_o  (core_id_err_o),
      .count_o        (count_o)
   );

   typedef struct {
      logic [31:0] core_id;
      logic [3:0]  id;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   rr_m = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic fpu_tag_t mk_tag(input int core, input int id, input int addr, input bit fp);
      fpu_tag_t t;
      t.addr = 5'(addr); t.rd_is_fp = fp; t.id = 4'(id); t.core_id = 32'(core);
      return t;
   endfunction

   function automatic mem_metadata_t mk_meta(input int core, input int id, input int rd, input bit we);
      mem_metadata_t m;
      m.id = 4'(id); m.rd = 5'(rd); m.we = we; m.core_id = 32'(core);
      return m;
   endfunction

   // One bus cycle: drive, check the expected grant, then commit accepted items to the model.
   task automatic cycle(input logic fv, input logic [31:0] fd, input fpu_tag_t ft,
                        input logic mv, input logic [31:0] md, input mem_metadata_t mm,
                        input logic [NC-1:0] rdy, input logic fl,
                        output logic fa, output logic ma);
      logic open, fwin, mwin, idle, exp_fr, exp_mr;
      @(negedge clk);
      fpu_valid_i = fv; fpu_data_i = fd; fpu_tag_i = ft;
      mem_valid_i = mv; mem_data_i = md; mem_meta_i = mm;
      result_ready_i = rdy; flush_i = fl;
      #1;
      open = (exp_q.size() < DEP) && !fl;
      idle = !fv && !mv;
      fwin = (fv && mv) ? (rr_m == 0) : fv;
      mwin = (fv && mv) ? (rr_m == 1) : mv;
      exp_fr = open && (idle || fwin);
      exp_mr = open && (idle || mwin);
      chk("fpu_ready", 64'(fpu_ready_o), 64'(exp_fr));
      chk("mem_ready", 64'(mem_ready_o), 64'(exp_mr));
      fa = fv && exp_fr;
      ma = mv && exp_mr;
      @(posedge clk); #1;
      if (fl) exp_q.delete();
      if (fa) exp_q.push_back('{ft.core_id, ft.id, ft.addr, !ft.rd_is_fp, fd});
      if (ma) exp_q.push_back('{mm.core_id, mm.id, mm.rd, mm.we, md});
      if (fv && mv && (fa || ma)) rr_m = 1 - rr_m;
   endtask

   task automatic idle(input logic [NC-1:0] rdy, input int n);
      logic a, b;
      repeat (n) cycle(1'b0, '0, '0, 1'b0, '0, '0, rdy, 1'b0, a, b);
   endtask

   // Monitor: compares whatever the DUT presents against the head of the model.
   exp_t          h;
   logic [NC-1:0] ev;
   x_result_t     r;
   initial begin
      forever begin
         @(negedge clk); #2;
         if (rst_ni) begin
            chk("count", 64'(count_o), 64'(exp_q.size()));
            if (exp_q.size() == 0) begin
               chk("empty_valid", 64'(result_valid_o), 64'(0));
               chk("empty_err", 64'(core_id_err_o), 64'(0));
            end else begin
               h = exp_q[0];
               if (h.core_id < NC) begin
                  ev = NC'(1) << h.core_id;
                  r = '0; r.id = h.id; r.data = h.data; r.rd = h.rd; r.we = h.we;
                  chk("valid", 64'(result_valid_o), 64'(ev));
                  chk("payload", 64'(result_o), 64'(r));
                  chk("err_quiet", 64'(core_id_err_o), 64'(0));
                  if (!flush_i && (result_ready_i & ev) != '0) void'(exp_q.pop_front());
               end else begin
                  chk("bad_core_valid", 64'(result_valid_o), 64'(0));
                  chk("bad_core_err", 64'(core_id_err_o), 64'(!flush_i));
                  if (!flush_i) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   logic          fa, ma, fp_pend, mp_pend;
   logic [31:0]   fd, md;
   fpu_tag_t      ft;
   mem_metadata_t mm;
   int            fk, mk, pv, pr;

   function automatic int rand_core();
      int s;
      s = int'($urandom_range(99));
      if (s < 5) return 7;
      if (s < 7) return int'($urandom);
      return int'($urandom_range(NC - 1));
   endfunction

   initial begin
      #12;
      chk("rst_valid", 64'(result_valid_o), 64'(0));
      chk("rst_count", 64'(count_o), 64'(0));
      chk("rst_err", 64'(core_id_err_o), 64'(0));
      chk("rst_fpu_ready", 64'(fpu_ready_o), 64'(1));
      chk("rst_mem_ready", 64'(mem_ready_o), 64'(1));
      @(negedge clk); rst_ni = 1'b1;

      // Single FPU result to core 1
      cycle(1'b1, 32'hDEADBEEF, mk_tag(1, 3, 5, 1'b0), 1'b0, '0, '0, 2'b10, 1'b0, fa, ma);
      idle(2'b10, 2);

      // Contention with outputs stalled, then drain
      fk = 0; mk = 0;
      repeat (5) begin
         cycle(1'b1, 32'hF0 + fk, mk_tag(fk % NC, fk, fk + 8, fk[0]),
               1'b1, 32'hA0 + mk, mk_meta(mk % NC, mk + 4, mk + 16, 1'b1), '0, 1'b0, fa, ma);
         if (fa) fk++;
         if (ma) mk++;
      end
      idle('1, 6);

      // Head-of-line blocking: core0 entry stalls a core1 entry
      cycle(1'b1, 32'h11, mk_tag(0, 1, 1, 1'b0), 1'b0, '0, '0, 2'b10, 1'b0, fa, ma);
      cycle(1'b0, '0, '0, 1'b1, 32'h22, mk_meta(1, 2, 2, 1'b1), 2'b10, 1'b0, fa, ma);
      idle(2'b10, 10);
      idle(2'b11, 3);

      // Out-of-range core id followed by a normal entry
      cycle(1'b1, 32'h77, mk_tag(7, 7, 7, 1'b0), 1'b0, '0, '0, 2'b11, 1'b0, fa, ma);
      cycle(1'b0, '0, '0, 1'b1, 32'h33, mk_meta(0, 3, 3, 1'b0), 2'b11, 1'b0, fa, ma);
      idle('1, 3);

      // Full buffer with a pop: no push that cycle, push accepted the next
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'h100 + i, mk_tag(i % NC, i, i, 1'b0), 1'b0, '0, '0, '0, 1'b0, fa, ma);
      cycle(1'b1, 32'h1FF, mk_tag(1, 9, 9, 1'b1), 1'b0, '0, '0, '1, 1'b0, fa, ma);
      cycle(1'b1, 32'h1FF, mk_tag(1, 9, 9, 1'b1), 1'b0, '0, '0, '0, 1'b0, fa, ma);
      idle('1, 6);

      // Flush with three entries held and a push pending
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h200 + i, mk_tag(i % NC, i, i, 1'b0), 1'b0, '0, '0, '0, 1'b0, fa, ma);
      cycle(1'b1, 32'h2FF, mk_tag(0, 5, 5, 1'b0), 1'b1, 32'h2EE, mk_meta(1, 6, 6, 1'b1), '0, 1'b1, fa, ma);
      idle('0, 1);
      idle('1, 2);

      // Asynchronous reset while draining
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h300 + i, mk_tag(i % NC, i, i, 1'b0), 1'b0, '0, '0, '0, 1'b0, fa, ma);
      @(negedge clk);
      fpu_valid_i = 1'b0; mem_valid_i = 1'b0; result_ready_i = '1; flush_i = 1'b0;
      #3 rst_ni = 1'b0;
      #1;
      chk("midrst_valid", 64'(result_valid_o), 64'(0));
      chk("midrst_count", 64'(count_o), 64'(0));
      exp_q.delete();
      rr_m = 0;
      @(negedge clk); #3 rst_ni = 1'b1;
      idle('1, 2);

      // Randomized traffic in phases of varying load and back-pressure
      fp_pend = 1'b0; mp_pend = 1'b0;
      for (int ph = 0; ph < 4; ph++) begin
         pv = (ph == 0) ? 30 : (ph == 1) ? 90 : (ph == 2) ? 60 : 95;
         pr = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 60 : 10;
         for (int i = 0; i < 900; i++) begin
            logic [NC-1:0] rdy;
            if (!fp_pend) begin
               fp_pend = (int'($urandom_range(99)) < pv);
               fd = $urandom;
               ft = mk_tag(rand_core(), int'($urandom_range(15)), int'($urandom_range(31)), bit'($urandom_range(1)));
            end
            if (!mp_pend) begin
               mp_pend = (int'($urandom_range(99)) < pv);
               md = $urandom;
               mm = mk_meta(rand_core(), int'($urandom_range(15)), int'($urandom_range(31)), bit'($urandom_range(1)));
            end
            for (int c = 0; c < NC; c++) rdy[c] = (int'($urandom_range(99)) < pr);
            cycle(fp_pend, fd, ft, mp_pend, md, mm, rdy, (int'($urandom_range(99)) < 2), fa, ma);
            if (fa) fp_pend = 1'b0;
            if (ma) mp_pend = 1'b0;
         end
      end
      idle('1, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
